// File: rtl/muldiv_ctrl_pkg.sv
// Shared RV32I types used by the muldiv controller slice:
// data word, M-extension funct3 encoding, controller state and op bundle.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } muldiv_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } muldiv_ctrl_state_t;

    typedef struct packed {
        muldiv_funct3_t funct3;
        rv32i_word      a;
        rv32i_word      b;
    } muldiv_op_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Requester-side bundle of the muldiv controller: two request ports,
// one-hot grant, one-hot response valid, shared result word, per-port ready.
interface muldiv_ctrl_if;
    import rv32i_types::*;

    logic [1:0]     req;
    rv32i_word      req_a0;
    rv32i_word      req_b0;
    rv32i_word      req_a1;
    rv32i_word      req_b1;
    muldiv_funct3_t req_funct3_0;
    muldiv_funct3_t req_funct3_1;
    logic [1:0]     gnt;
    logic [1:0]     rsp_valid;
    rv32i_word      rsp_data;
    logic [1:0]     rsp_ready;

    modport master (
        output req, req_a0, req_b0, req_a1, req_b1,
        output req_funct3_0, req_funct3_1, rsp_ready,
        input  gnt, rsp_valid, rsp_data
    );

    modport slave (
        input  req, req_a0, req_b0, req_a1, req_b1,
        input  req_funct3_0, req_funct3_1, rsp_ready,
        output gnt, rsp_valid, rsp_data
    );

endinterface

// File: rtl/muldiv_rr_arbiter.sv
// Two-way round-robin arbiter: req/advance in, one-hot gnt out.
// last_q remembers the most recent winner; ties go to the other port.
module muldiv_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // reset to 1 so requester 0 wins the first tie
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (advance) begin
            if (req == 2'b11)
                gnt = last_q ? 2'b01 : 2'b10;
            else
                gnt = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= 1'b1;
        else if (|gnt)
            last_q <= gnt[1];
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Shares one muldiv unit between two requesters with a one-entry result cache.
// Ports: clk, rst_n, bus (requester side), md_* (muldiv unit side, md_rst active-high).
module muldiv_ctrl
    import rv32i_types::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    muldiv_ctrl_if.slave   bus,
    output logic           md_rst,
    output logic           md_en,
    output rv32i_word      md_a,
    output rv32i_word      md_b,
    output muldiv_funct3_t md_funct3,
    output logic           md_mem_stall,
    input  logic           md_resp,
    input  rv32i_word      md_f
);

    muldiv_ctrl_state_t state_q, state_d;
    muldiv_op_t op_q, op_sel, cache_q;
    rv32i_word  res_q, cache_f_q;
    logic       id_q, cache_v_q, hit;
    logic [1:0] gnt, rsp_valid;

    muldiv_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req),
        .advance (state_q == IDLE),
        .gnt     (gnt)
    );

    always_comb begin
        op_sel = gnt[1]
            ? '{bus.req_funct3_1, bus.req_a1, bus.req_b1}
            : '{bus.req_funct3_0, bus.req_a0, bus.req_b0};
    end

    assign hit = CACHE_EN && cache_v_q && (cache_q == op_sel);

    always_comb begin
        state_d   = state_q;
        md_en     = 1'b0;
        rsp_valid = 2'b00;
        unique case (state_q)
            IDLE:  if (|gnt) state_d = hit ? RESP : ISSUE;
            ISSUE: begin
                md_en   = 1'b1;
                state_d = WAIT;
            end
            WAIT:  if (md_resp) state_d = RESP;
            RESP: begin
                rsp_valid[id_q] = 1'b1;
                if (bus.rsp_ready[id_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            id_q      <= 1'b0;
            res_q     <= '0;
            cache_q   <= '0;
            cache_f_q <= '0;
            cache_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |gnt) begin
                op_q <= op_sel;
                id_q <= gnt[1];
                if (hit) res_q <= cache_f_q;
            end
            // result is taken in the md_resp cycle, so no stall is needed
            if (state_q == WAIT && md_resp) begin
                res_q     <= md_f;
                cache_q   <= op_q;
                cache_f_q <= md_f;
                cache_v_q <= CACHE_EN;
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = res_q;
    assign md_a          = op_q.a;
    assign md_b          = op_q.b;
    assign md_funct3     = op_q.funct3;
    assign md_mem_stall  = 1'b0;
    // unit reset tracks ours so an in-flight op is dropped with us
    assign md_rst        = ~rst_n;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural unit model, per-cycle scoreboard
// derived from arithmetic/latency rules, plus directed literal checks.
module tb_muldiv_ctrl;
    import rv32i_types::*;

    localparam int UL = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           md_rst, md_en, md_mem_stall, md_resp;
    rv32i_word      md_a, md_b, md_f;
    muldiv_funct3_t md_funct3;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.CACHE_EN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .md_rst       (md_rst),
        .md_en        (md_en),
        .md_a         (md_a),
        .md_b         (md_b),
        .md_funct3    (md_funct3),
        .md_mem_stall (md_mem_stall),
        .md_resp      (md_resp),
        .md_f         (md_f)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timeout", nm);
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                return p[63:32];
            end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // shared muldiv unit: result UL cycles after the md_en cycle
    logic [2:0]  u_f3;
    logic [31:0] u_a, u_b;
    int          u_cnt;
    always @(posedge clk or posedge md_rst) begin
        if (md_rst) begin
            u_cnt   <= 0;
            md_resp <= 1'b0;
            md_f    <= '0;
        end else begin
            md_resp <= 1'b0;
            if (md_en) begin
                u_f3  <= md_funct3;
                u_a   <= md_a;
                u_b   <= md_b;
                u_cnt <= UL - 1;
            end else if (u_cnt != 0) begin
                u_cnt <= u_cnt - 1;
                if (u_cnt == 1) begin
                    md_resp <= 1'b1;
                    md_f    <= ref_md(u_f3, u_a, u_b);
                end
            end
        end
    end

    // scoreboard model
    bit          m_busy, m_last, m_id, m_hit, c_v;
    int          m_age, m_lat;
    logic [2:0]  m_f3, c_f3;
    logic [31:0] m_a, m_b, m_data, c_a, c_b, c_f;
    logic [1:0]  eg;
    logic [31:0] last_data [2];
    int          resp_cnt = 0;
    int          en_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0;
            c_v    = 0;
            m_last = 1;
        end else begin
            chk("md_mem_stall", md_mem_stall, 0);
            chk("md_rst", md_rst, 0);
            if (md_en) en_cnt++;
            if (!m_busy) begin
                // lone requester wins; on a tie the one not granted last
                if (bus.req == 2'b11) eg = 2'b01 << (1 - m_last);
                else eg = bus.req;
                chk("gnt", bus.gnt, eg);
                chk("idle_valid", bus.rsp_valid, 0);
                chk("idle_md_en", md_en, 0);
                if (eg != 0) begin
                    m_id  = eg[1];
                    m_f3  = m_id ? bus.req_funct3_1 : bus.req_funct3_0;
                    m_a   = m_id ? bus.req_a1 : bus.req_a0;
                    m_b   = m_id ? bus.req_b1 : bus.req_b0;
                    m_hit = c_v && c_f3 == m_f3 && c_a == m_a && c_b == m_b;
                    m_data = m_hit ? c_f : ref_md(m_f3, m_a, m_b);
                    if (!m_hit) begin
                        c_v = 1; c_f3 = m_f3; c_a = m_a; c_b = m_b;
                        c_f = m_data;
                    end
                    m_busy = 1;
                    m_age  = 0;
                    m_lat  = m_hit ? 1 : UL + 2;
                    m_last = m_id;
                end
            end else begin
                m_age++;
                chk("busy_gnt", bus.gnt, 0);
                chk("md_en", md_en, (!m_hit && m_age == 1));
                if (!m_hit && m_age < m_lat) begin
                    chk("md_a", md_a, m_a);
                    chk("md_b", md_b, m_b);
                    chk("md_funct3", md_funct3, m_f3);
                end
                if (m_age >= m_lat) begin
                    chk("rsp_valid", bus.rsp_valid, 2'b01 << m_id);
                    chk("rsp_data", bus.rsp_data, m_data);
                    if (bus.rsp_ready[m_id]) begin
                        m_busy = 0;
                        last_data[m_id] = bus.rsp_data;
                        resp_cnt++;
                    end
                end else begin
                    chk("early_valid", bus.rsp_valid, 0);
                end
            end
        end
    end

    task automatic issue(input int id, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            bus.req_funct3_0 = muldiv_funct3_t'(f3);
            bus.req_a0 = a;
            bus.req_b0 = b;
        end else begin
            bus.req_funct3_1 = muldiv_funct3_t'(f3);
            bus.req_a1 = a;
            bus.req_b1 = b;
        end
        bus.req[id] = 1'b1;
    endtask

    // drop the request after its grant and scramble its operands
    task automatic wait_gnt(input int id);
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.gnt[id]) begin
                seen = 1;
                break;
            end
        end
        if (!seen) timeout("wait_gnt");
        @(posedge clk);
        #1;
        bus.req[id] = 1'b0;
        if (id == 0) begin
            bus.req_a0 = $urandom;
            bus.req_b0 = $urandom;
            bus.req_funct3_0 = MD_REMU;
        end else begin
            bus.req_a1 = $urandom;
            bus.req_b1 = $urandom;
            bus.req_funct3_1 = MD_MULH;
        end
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 100; i++) begin
            if (resp_cnt >= n) break;
            @(negedge clk);
        end
        if (resp_cnt < n) timeout("wait_rsp");
        @(posedge clk);
        #1;
    endtask

    int n, e;
    bit seen_v;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.req = 2'b00;
        bus.req_a0 = '0; bus.req_b0 = '0;
        bus.req_a1 = '0; bus.req_b1 = '0;
        bus.req_funct3_0 = MD_MUL;
        bus.req_funct3_1 = MD_MUL;
        bus.rsp_ready = 2'b11;
        #2;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_data", bus.rsp_data, 0);
        chk("rst_md_en", md_en, 0);
        chk("rst_md_a", md_a, 0);
        chk("rst_md_f3", md_funct3, 0);
        chk("rst_md_rst", md_rst, 1);
        chk("ref_mul", ref_md(3'd0, 7, 32'hFFFFFFFD), 32'hFFFFFFEB);
        chk("ref_rem_ovf", ref_md(3'd6, 32'h80000000, 32'hFFFFFFFF), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // both request together: 0 first after reset, then 1
        n = resp_cnt;
        issue(0, MD_DIV, 100, 7);
        issue(1, MD_REM, 100, 7);
        wait_gnt(0);
        wait_gnt(1);
        wait_rsp(n + 2);
        chk("div_100_7", last_data[0], 14);
        chk("rem_100_7", last_data[1], 2);

        // signed multiply
        e = en_cnt; n = resp_cnt;
        issue(0, MD_MUL, 7, 32'hFFFFFFFD);
        wait_gnt(0);
        wait_rsp(n + 1);
        chk("mul_7_m3", last_data[0], 32'hFFFFFFEB);
        chk("mul_en_once", en_cnt - e, 1);

        // divu twice: second hits the cache
        e = en_cnt; n = resp_cnt;
        issue(0, MD_DIVU, 32'hFFFFFFFF, 3);
        wait_gnt(0);
        wait_rsp(n + 1);
        chk("divu_1", last_data[0], 32'h55555555);
        issue(0, MD_DIVU, 32'hFFFFFFFF, 3);
        wait_gnt(0);
        chk("hit_latency", bus.rsp_valid, 2'b01);
        wait_rsp(n + 2);
        chk("divu_2", last_data[0], 32'h55555555);
        chk("divu_en_cnt", en_cnt - e, 1);

        // hold RESP with ready low; port 1 waits, its ready is ignored
        n = resp_cnt;
        bus.rsp_ready = 2'b10;
        issue(0, MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_gnt(0);
        issue(1, MD_REMU, 10, 3);
        seen_v = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid[0]) begin
                seen_v = 1;
                break;
            end
        end
        if (!seen_v) timeout("hold_valid_rise");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.rsp_valid, 2'b01);
            chk("hold_data", bus.rsp_data, 32'hFFFFFFFE);
            chk("hold_gnt", bus.gnt, 0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 2'b11;
        wait_gnt(1);
        wait_rsp(n + 2);
        chk("mulhu", last_data[0], 32'hFFFFFFFE);
        chk("remu_10_3", last_data[1], 1);

        // edge cases pass through and are cacheable
        e = en_cnt; n = resp_cnt;
        issue(1, MD_DIV, 5, 0);
        wait_gnt(1);
        wait_rsp(n + 1);
        chk("div_by_0", last_data[1], 32'hFFFFFFFF);
        issue(0, MD_DIV, 5, 0);
        wait_gnt(0);
        wait_rsp(n + 2);
        chk("div_by_0_hit", last_data[0], 32'hFFFFFFFF);
        chk("div_by_0_en", en_cnt - e, 1);
        issue(0, MD_REM, 32'h80000000, 32'hFFFFFFFF);
        wait_gnt(0);
        wait_rsp(n + 3);
        chk("rem_ovf", last_data[0], 0);

        // reset while the unit is busy
        issue(0, MD_DIVU, 1000, 10);
        wait_gnt(0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("wrst_gnt", bus.gnt, 0);
        chk("wrst_valid", bus.rsp_valid, 0);
        chk("wrst_md_en", md_en, 0);
        chk("wrst_data", bus.rsp_data, 0);
        chk("wrst_md_a", md_a, 0);
        chk("wrst_md_b", md_b, 0);
        chk("wrst_md_f3", md_funct3, 0);
        chk("wrst_md_rst", md_rst, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        e = en_cnt; n = resp_cnt;
        issue(0, MD_DIVU, 1000, 10);
        wait_gnt(0);
        wait_rsp(n + 1);
        chk("post_rst_data", last_data[0], 100);
        chk("post_rst_miss", en_cnt - e, 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter CACHE_EN, default 1: enables the one-entry last-result cache.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  in  2  per-requester operation request; held by the requester until granted.
REQ-005 SHALL have ports req_a0, req_b0, req_a1, req_b1  in  32 each  operands (rv32i_word).
REQ-006 SHALL have ports req_funct3_0, req_funct3_1  in  muldiv_funct3_t  operation select.
REQ-007 SHALL have port gnt  out  2  one-hot, single-cycle acceptance pulse.
REQ-008 SHALL have port rsp_valid  out  2  one-hot result-valid.
REQ-009 SHALL have port rsp_data  out  32  result word.
REQ-010 SHALL have port rsp_ready  in  2  per-requester result acceptance.
REQ-011 SHALL have ports md_en  out  1, md_a and md_b  out  32 each, md_funct3  out  muldiv_funct3_t: drive muldiv_en, a, b and funct3 of the shared muldiv unit.
REQ-012 SHALL have ports md_mem_stall  out  1, md_resp  in  1 and md_f  in  32: connect to mem_stall, muldiv_resp and f of the unit.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-014 In IDLE with any req bit set: grant one requester, pulse gnt for that cycle, and latch its operands, funct3 and ID on the clock edge.
REQ-015 Arbitration SHALL be round-robin: one request wins alone; when both request, the requester not most recently granted wins; after reset, requester 0 wins.
REQ-016 On grant, on a cache hit (CACHE_EN=1, cache valid, and funct3, a and b all equal the cached entry): next state RESP, with rsp_data taken from the cache; md_en is not asserted.
REQ-017 On grant, on a cache miss: next state ISSUE.
REQ-018 ISSUE SHALL assert md_en for exactly one cycle, then go to WAIT.
REQ-019 md_a, md_b and md_funct3 SHALL equal the latched values continuously from ISSUE through WAIT.
REQ-020 In WAIT, when md_resp=1: capture md_f into the result register, write {funct3, a, b, md_f} into the cache, set the cache valid, and go to RESP.
REQ-021 md_mem_stall SHALL be constant 0, because the result is captured in the md_resp cycle.
REQ-022 RESP SHALL assert rsp_valid[ID] with rsp_data stable until rsp_ready[ID]=1, then go to IDLE.
REQ-023 After a RESP handshake there SHALL be no grant in the same cycle; the minimum gap between grants is 1 IDLE cycle.
REQ-024 The ready bit of the non-granted requester SHALL be ignored, and gnt SHALL be 0 in all states other than IDLE.
REQ-025 Latency SHALL be: on a hit, rsp_valid rises 1 cycle after gnt; on a miss, rsp_valid rises (unit latency + 2) cycles after gnt.
REQ-026 Request changes on either port after gnt SHALL NOT affect the in-flight operation.
REQ-027 Edge-case results (divide by zero, overflow) SHALL be passed through from the unit unchanged and SHALL be cacheable.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE; gnt, rsp_valid, md_en, md_mem_stall, rsp_data, md_a, md_b=0; md_funct3=0; cache invalid; RR pointer set to favour requester 0.
REQ-029 The top level SHALL hold the muldiv unit's active-high rst asserted whenever rst_n=0, so that a reset during WAIT leaves no orphan operation.

Structure
REQ-030 rv32i_word and muldiv_funct3_t SHALL come from rv32i_types.
REQ-031 The state enum muldiv_ctrl_state_t SHALL be added to rv32i_types.
REQ-032 The two-way round-robin grant logic (req, advance -> one-hot gnt, with pointer register) SHALL be the sub-module muldiv_rr_arbiter.

Verification
REQ-033 Scenario: req0 mul a=7, b=0xFFFFFFFD -> gnt[0]; md_en high 1 cycle; rsp_valid[0] with rsp_data=0xFFFFFFEB.
REQ-034 Scenario: same cycle, req0 div 100/7 and req1 rem 100/7 -> gnt[0] first with data 14; then gnt[1] with data 2.
REQ-035 Scenario: divu 0xFFFFFFFF/3 issued twice -> both return 0x55555555; the second has no md_en and rsp_valid 1 cycle after gnt.
REQ-036 Scenario: rsp_ready low for 5 cycles in RESP -> rsp_valid and rsp_data stable, no gnt; handshake then IDLE.
REQ-037 Scenario: div a=5, b=0 -> 0xFFFFFFFF; rem a=0x80000000, b=0xFFFFFFFF -> 0.
REQ-038 Scenario: rst_n pulsed low during WAIT -> all outputs 0 immediately; a repeat of the prior op then misses and asserts md_en.
